// File: rtl/dr_fetch_seq.sv
// Fetch/execute sequencer emitting dual-rail return-to-zero PH0/PC/I wavefronts,
// each DATA or NULL wavefront paced by the downstream completion signal ko.
module dr_fetch_seq #(
    parameter int WIDTH    = 4,
    parameter int PC_RESET = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ko,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             jmp_en,
    input  logic [WIDTH-1:0] jmp_addr,
    output logic             PH0_t,
    output logic             PH0_f,
    output logic [WIDTH-1:0] PC_t,
    output logic [WIDTH-1:0] PC_f,
    output logic [WIDTH-1:0] I_t,
    output logic [WIDTH-1:0] I_f,
    output logic             busy,
    output logic             err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, F_DATA, F_NULL, E_DATA, E_NULL} state_t;

    state_t           st_q, st_d;
    logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             ph_t_q, ph_t_d, ph_f_q, ph_f_d, busy_q, busy_d;
    logic [WIDTH-1:0] pc_t_q, pc_t_d, pc_f_q, pc_f_d, i_t_q, i_t_d, i_f_q, i_f_d;

    always_comb begin
        st_d  = st_q;
        pc_d  = pc_q;
        ir_d  = ir_q;
        cnt_d = cnt_q;
        err_d = err_q;
        // Once err is set everything freezes until reset.
        if (!err_q) begin
            if (st_q != IDLE && cnt_q == CW'(TIMEOUT)) begin
                err_d = 1'b1;
            end else begin
                case (st_q)
                    IDLE:   if (en && ko) st_d = F_DATA;
                    F_DATA: if (!ko) begin
                        st_d = F_NULL;
                        ir_d = mem_data;
                    end
                    F_NULL: if (ko) st_d = E_DATA;
                    E_DATA: if (!ko) begin
                        st_d = E_NULL;
                        pc_d = jmp_en ? jmp_addr : pc_q + 1'b1;
                    end
                    E_NULL: if (ko) st_d = en ? F_DATA : IDLE;
                    default: st_d = IDLE;
                endcase
                if (st_d != st_q)      cnt_d = '0;
                else if (st_q != IDLE) cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Outputs are derived from next-state values so the rails register on the
    // same edge as the state, with no combinational input-to-output path.
    always_comb begin
        ph_t_d = 1'b0;
        ph_f_d = 1'b0;
        pc_t_d = '0;
        pc_f_d = '0;
        i_t_d  = '0;
        i_f_d  = '0;
        busy_d = (st_d != IDLE);
        if (!err_d && (st_d == F_DATA || st_d == E_DATA)) begin
            ph_t_d = (st_d == F_DATA);
            ph_f_d = (st_d == E_DATA);
            pc_t_d = pc_d;
            pc_f_d = ~pc_d;
            i_t_d  = ir_d;
            i_f_d  = ~ir_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            pc_q   <= WIDTH'(PC_RESET);
            ir_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            ph_t_q <= 1'b0;
            ph_f_q <= 1'b0;
            pc_t_q <= '0;
            pc_f_q <= '0;
            i_t_q  <= '0;
            i_f_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            ph_t_q <= ph_t_d;
            ph_f_q <= ph_f_d;
            pc_t_q <= pc_t_d;
            pc_f_q <= pc_f_d;
            i_t_q  <= i_t_d;
            i_f_q  <= i_f_d;
            busy_q <= busy_d;
        end
    end

    assign PH0_t = ph_t_q;
    assign PH0_f = ph_f_q;
    assign PC_t  = pc_t_q;
    assign PC_f  = pc_f_q;
    assign I_t   = i_t_q;
    assign I_f   = i_f_q;
    assign busy  = busy_q;
    assign err   = err_q;
endmodule

// File: tb/tb_dr_fetch_seq.sv
// Bench for dr_fetch_seq: directed test-plan checks plus randomized ko/en/jump
// traffic against a cycle-level model of the fetch/execute handshake.
module tb_dr_fetch_seq;
    localparam int W  = 4;
    localparam int TO = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0, ko = 1'b1, jmp_en = 1'b0;
    logic [W-1:0] mem_data = '0, jmp_addr = '0;
    logic PH0_t, PH0_f, busy, err;
    logic [W-1:0] PC_t, PC_f, I_t, I_f;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    dr_fetch_seq #(.WIDTH(W), .PC_RESET(0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ko(ko), .mem_data(mem_data),
        .jmp_en(jmp_en), .jmp_addr(jmp_addr), .PH0_t(PH0_t), .PH0_f(PH0_f),
        .PC_t(PC_t), .PC_f(PC_f), .I_t(I_t), .I_f(I_f), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: phase 0=idle 1=fetch-data 2=fetch-null 3=exec-data 4=exec-null.
    int m_ph = 0, m_pc = 0, m_ir = 0, m_hold = 0;
    bit m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_pc = 0; m_ir = 0; m_hold = 0; m_err = 1'b0;
        end else if (m_err) begin
            // frozen
        end else if (m_ph != 0 && m_hold == TO) begin
            m_err = 1'b1;
        end else begin
            bit adv;
            case (m_ph)
                0:       adv = en && ko;
                1, 3:    adv = !ko;
                default: adv = ko;
            endcase
            if (adv) begin
                if (m_ph == 1) m_ir = int'(mem_data);
                if (m_ph == 3) m_pc = jmp_en ? int'(jmp_addr) : (m_pc + 1) % (MASK + 1);
                m_ph = (m_ph == 4) ? (en ? 1 : 0) : m_ph + 1;
                m_hold = 0;
            end else if (m_ph != 0) begin
                m_hold++;
            end
        end
    end

    bit prev_data = 1'b0;
    int prev_val = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            bit data, ndata;
            int cur;
            data = !m_err && (m_ph == 1 || m_ph == 3);
            chk("ph0_t", PH0_t, data && m_ph == 1);
            chk("ph0_f", PH0_f, data && m_ph == 3);
            chk("pc_t", PC_t, data ? m_pc : 0);
            chk("pc_f", PC_f, data ? (~m_pc & MASK) : 0);
            chk("i_t", I_t, data ? m_ir : 0);
            chk("i_f", I_f, data ? (~m_ir & MASK) : 0);
            chk("busy", busy, m_ph != 0);
            chk("err", err, m_err);
            // Protocol scoreboard straight from the rails.
            chk("rail_tf11", ((PH0_t & PH0_f) != 0) || ((PC_t & PC_f) != 0) || ((I_t & I_f) != 0), 0);
            ndata = PH0_t | PH0_f;
            chk("wavefront_whole", ndata ? ((PC_t ^ PC_f) == MASK[W-1:0] && (I_t ^ I_f) == MASK[W-1:0])
                                         : (PC_t == 0 && PC_f == 0 && I_t == 0 && I_f == 0), 1);
            cur = {PH0_t, PH0_f, PC_t, I_t};
            chk("data_no_null_between", prev_data && ndata && cur != prev_val, 0);
            prev_data = ndata;
            prev_val = cur;
        end
    end

    // Apply inputs just after a falling edge, let one rising edge pass, return
    // just after the next falling edge with outputs settled.
    task automatic tick(input logic e, input logic k, input logic j = 1'b0,
                        input logic [W-1:0] ja = '0, input logic [W-1:0] md = '0);
        en = e; ko = k; jmp_en = j; jmp_addr = ja; mem_data = md;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        @(negedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1);
            chk("rst_idle_busy", busy, 0);
            chk("rst_idle_rails", {PH0_t, PH0_f, PC_t, PC_f, I_t, I_f}, 0);
        end

        tick(1'b1, 1'b1, 1'b0, 4'h0, 4'hA);
        chk("f1_ph0_t", PH0_t, 1);
        chk("f1_pc", {PC_t, PC_f}, 8'h0F);
        chk("f1_busy", busy, 1);
        tick(1'b1, 1'b0, 1'b0, 4'h0, 4'hA);
        chk("f1_null", {PH0_t, PH0_f, PC_t, PC_f, I_t, I_f}, 0);
        tick(1'b1, 1'b1);
        chk("e1_ph0_f", {PH0_t, PH0_f}, 2'b01);
        chk("e1_ir", {I_t, I_f}, 8'hA5);
        chk("e1_pc", {PC_t, PC_f}, 8'h0F);
        tick(1'b1, 1'b0, 1'b1, 4'hF);
        tick(1'b1, 1'b1);
        chk("f2_pc_jmpF", PC_t, 4'hF);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("f3_pc_wrap", {PC_t, PC_f}, 8'h0F);

        tick(1'b1, 1'b1, 1'b1, 4'h6);
        tick(1'b1, 1'b0, 1'b1, 4'h6);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("f4_jmp_ignored", PC_t, 4'h1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 4'h6);
        tick(1'b1, 1'b1);
        chk("f5_pc_jmp6", {PC_t, PC_f}, 8'h69);

        for (int i = 0; i < TO; i++) tick(1'b1, 1'b1);
        chk("to_before_err", err, 0);
        chk("to_before_ph0", PH0_t, 1);
        tick(1'b1, 1'b1);
        chk("to_err", err, 1);
        chk("to_rails_null", {PH0_t, PH0_f, PC_t, PC_f, I_t, I_f}, 0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'(i % 2));
        chk("to_frozen_err", err, 1);
        chk("to_frozen_null", {PH0_t, PH0_f, PC_t, I_t}, 0);
        rst_n = 1'b0;
        tick(1'b0, 1'b1);
        rst_n = 1'b1;
        chk("to_reset_clears", err, 0);

        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 4'h0, 4'h3);
        tick(1'b1, 1'b1);
        chk("ar_in_edata", {PH0_f, I_t}, 5'h13);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_async_null", {PH0_t, PH0_f, PC_t, PC_f, I_t, I_f}, 0);
        chk("ar_async_busy", busy, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        tick(1'b1, 1'b1);
        chk("ar_restart_pc", {PC_t, PC_f}, 8'h0F);
        chk("ar_restart_ir", {I_t, I_f}, 8'h0F);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_n = 1'b0;
                tick(1'b0, 1'b1);
                rst_n = 1'b1;
            end
            tick(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 4'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
